// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data memory arbiter: FSM encoding, port IDs
// and the legal latency bound that sizes the latency counter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = $clog2(LATENCY_MAX + 1);

endpackage : mem_arb_pkg

// File: rtl/mem_arb_pick.sv
// Combinational requester picker. MEM_ARB_FAIR_EN selects round-robin on
// contention; otherwise the data port always beats the fetch port.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic dm_req,
  input  logic last_grant,
  output logic grant,
  output logic valid
);

`ifdef MEM_ARB_FAIR_EN
  always_comb begin
    // NOTE: every output gets a default before any branch, so no latch is inferred.
    grant = PORT_DM;
    valid = if_req | dm_req;
    if (if_req && dm_req) begin
      grant = (last_grant == PORT_DM) ? PORT_IF : PORT_DM;
    end else if (if_req) begin
      grant = PORT_IF;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant = PORT_DM;
    valid = if_req | dm_req;
    if (!dm_req) begin
      grant = PORT_IF;
    end
  end
`endif

endmodule : mem_arb_pick

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency, non-pipelined memory between the fetch and data ports.
// Optional round-robin arbitration on contention: define MEM_ARB_FAIR_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_err,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

  arb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             gnt_port;
  logic             gnt_wr;
  logic             last_grant;
  logic             pick_port;
  logic             pick_valid;
  logic             capture;

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .last_grant (last_grant),
    .grant      (pick_port),
    .valid      (pick_valid)
  );

  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done & ~dm_err;

  // Read data is sampled on the last latency cycle: straight out of ISSUE when
  // LATENCY is 1, otherwise when the incremented counter reaches LATENCY.
  always_comb begin
    cnt_inc = cnt + CNT_W'(1);
    capture = 1'b0;
    if (state == ISSUE && LATENCY == 1) capture = 1'b1;
    if (state == WAIT && cnt_inc == LAT_CNT) capture = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      gnt_port   <= PORT_IF;
      gnt_wr     <= 1'b0;
      last_grant <= PORT_IF;
      if_rdata   <= '0;
      if_done    <= 1'b0;
      dm_rdata   <= '0;
      dm_done    <= 1'b0;
      dm_err     <= 1'b0;
      mem_en     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      dm_err  <= 1'b0;
      mem_en  <= 1'b0;
      mem_wr  <= 1'b0;

      case (state)
        IDLE: begin
          // The cycle showing dm_err is the rejected request's completion, so
          // the still-high request is not picked again.
          if (pick_valid && !dm_err) begin
            last_grant <= pick_port;
            if (pick_port == PORT_DM && dm_addr[0]) begin
              dm_err <= 1'b1;
            end else begin
              gnt_port <= pick_port;
              gnt_wr   <= (pick_port == PORT_DM) ? dm_wr : 1'b0;
              mem_en   <= 1'b1;
              mem_wr   <= (pick_port == PORT_DM) ? dm_wr : 1'b0;
              mem_addr <= (pick_port == PORT_DM) ? dm_addr : if_addr;
              if (pick_port == PORT_DM) mem_wdata <= dm_wdata;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt   <= CNT_W'(1);
          state <= (LATENCY == 1) ? DONE : WAIT;
        end
        WAIT: begin
          cnt <= cnt_inc;
          if (cnt_inc == LAT_CNT) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (capture) begin
        if (gnt_port == PORT_DM) begin
          dm_done <= 1'b1;
          if (!gnt_wr) dm_rdata <= mem_rdata;
        end else begin
          if_done  <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a LATENCY=4 instance for the main scenarios
// and a LATENCY=1 instance for minimum-latency back-to-back loads.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_wr;
  logic [15:0] if_addr, dm_addr, dm_wdata;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_done, if_stall, dm_done, dm_err, dm_stall, mem_en, mem_wr;

  logic        dm_req1;
  logic [15:0] dm_addr1;
  logic [15:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        if_done1, if_stall1, dm_done1, dm_err1, dm_stall1, mem_en1, mem_wr1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(4)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_err(dm_err), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(1'b0), .if_addr(16'h0000), .if_rdata(if_rdata1), .if_done(if_done1), .if_stall(if_stall1),
    .dm_req(dm_req1), .dm_wr(1'b0), .dm_addr(dm_addr1), .dm_wdata(16'h0000),
    .dm_rdata(dm_rdata1), .dm_done(dm_done1), .dm_err(dm_err1), .dm_stall(dm_stall1),
    .mem_en(mem_en1), .mem_wr(mem_wr1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1)
  );

  // Memory model: fixed contents plus the most recent store; read data is valid
  // only on the cycle the arbiter must sample it, 16'hDEAD otherwise.
  logic        st_valid;
  logic [15:0] st_addr, st_data;
  int          age;

  function automatic logic [15:0] rd(input logic [15:0] a);
    if (st_valid && a == st_addr) return st_data;
    case (a)
      16'h0000: return 16'hA5A5;
      16'h0010: return 16'hBEEF;
      16'h0030: return 16'h5A5A;
      default:  return 16'h0000;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      age <= 99;
    end else if (mem_en) begin
      age <= 0;
    end else if (age < 99) begin
      age <= age + 1;
    end
  end

  always @(posedge clk) begin
    if (mem_en && mem_wr) begin
      st_valid <= 1'b1;
      st_addr  <= mem_addr;
      st_data  <= mem_wdata;
    end
  end

  assign mem_rdata  = (!mem_en && age == 2) ? rd(mem_addr) : 16'hDEAD;
  assign mem_rdata1 = mem_en1 ? rd(mem_addr1) : 16'hDEAD;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int          kd, ki, ke, en, errs, dones, nd;
  logic [15:0] rdv, ird, first_addr;
  logic        first_wr, stall_ok, stall_done;
  logic [3:0]  seq;
  logic [7:0]  en_mask, done_mask;

  initial begin
    st_valid = 1'b0;
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_wr = 1'b0; dm_addr = '0; dm_wdata = '0;
    dm_req1 = 1'b0; dm_addr1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_mem_en",  mem_en,   0);
    check("rst_mem_wr",  mem_wr,   0);
    check("rst_dones",   {if_done, dm_done, dm_err}, 0);
    check("rst_stalls",  {if_stall, dm_stall}, 0);
    check("rst_rdata",   {if_rdata, dm_rdata}, 0);
    check("rst_mem_bus", {mem_addr, mem_wdata}, 0);

    // Single load from 0x0010.
    @(posedge clk); #1 dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0010;
    @(negedge clk);
    check("t1_stall_R", dm_stall, 1);
    kd = -1; ke = -1; en = 0; stall_ok = 1'b1; stall_done = 1'b1;
    first_addr = '0; first_wr = 1'b1; rdv = '0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1 if (kd > 0) dm_req = 1'b0;
      @(negedge clk);
      if (mem_en) begin
        en++;
        if (ke < 0) begin ke = k; first_addr = mem_addr; first_wr = mem_wr; end
      end
      if (dm_done && kd < 0) begin kd = k; rdv = dm_rdata; stall_done = dm_stall; end
      if (k <= 4 && !dm_stall) stall_ok = 1'b0;
    end
    check("t1_en_cycle",   ke, 1);
    check("t1_en_count",   en, 1);
    check("t1_en_addr",    first_addr, 16'h0010);
    check("t1_en_wr",      first_wr, 0);
    check("t1_done_cycle", kd, 5);
    check("t1_rdata",      rdv, 16'hBEEF);
    check("t1_stall_held", stall_ok, 1);
    check("t1_stall_done", stall_done, 0);

    // Simultaneous fetch (0x0000) and store (0x0020 <- 0x1234): store goes first.
    @(posedge clk); #1
    if_req = 1'b1; if_addr = 16'h0000;
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0020; dm_wdata = 16'h1234;
    kd = -1; ki = -1; en = 0; ird = '0; stall_ok = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1
      if (kd > 0) dm_req = 1'b0;
      if (ki > 0) if_req = 1'b0;
      @(negedge clk);
      if (mem_en) begin
        en++;
        if (en == 1) begin first_addr = mem_addr; first_wr = mem_wr; end
      end
      if (dm_done && kd < 0) kd = k;
      if (if_done && ki < 0) begin ki = k; ird = if_rdata; end
      if (k < 11 && !if_stall) stall_ok = 1'b0;
    end
    check("t2_first_addr", first_addr, 16'h0020);
    check("t2_first_wr",   first_wr, 1);
    check("t2_en_count",   en, 2);
    check("t2_dm_done",    kd, 5);
    check("t2_if_done",    ki, 11);
    check("t2_if_rdata",   ird, 16'hA5A5);
    check("t2_if_stall",   stall_ok, 1);
    check("t2_dm_rdata",   dm_rdata, 16'hBEEF);
    check("t2_stored",     {st_valid, st_addr, st_data}, {1'b1, 16'h0020, 16'h1234});

    // Misaligned data access is rejected without touching memory.
    @(posedge clk); #1 dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0021;
    en = 0; errs = 0; dones = 0; stall_done = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1 if (k == 2) dm_req = 1'b0;
      @(negedge clk);
      if (k == 1) begin
        check("t3_err_cycle", dm_err, 1);
        stall_done = dm_stall;
      end
      if (mem_en) en++;
      if (dm_err) errs++;
      if (dm_done) dones++;
    end
    check("t3_err_stall", stall_done, 0);
    check("t3_err_count", errs, 1);
    check("t3_no_mem_en", en, 0);
    check("t3_no_done",   dones, 0);

    // Reset during WAIT aborts the load; the next load completes normally.
    @(posedge clk); #1 dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0010;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("t4_rst_outs", {mem_en, mem_wr, dm_done, dm_err, if_done}, 0);
    check("t4_rst_regs", {dm_rdata, mem_addr}, 0);
    dm_req = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (dm_done || mem_en) dones++;
    end
    check("t4_aborted_quiet", dones, 0);
    @(posedge clk); #1 dm_req = 1'b1; dm_addr = 16'h0030;
    kd = -1; rdv = '0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1 if (kd > 0) dm_req = 1'b0;
      @(negedge clk);
      if (dm_done && kd < 0) begin kd = k; rdv = dm_rdata; end
    end
    check("t4_done_cycle", kd, 5);
    check("t4_rdata",      rdv, 16'h5A5A);

    // Continuous contention from a fresh reset.
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    if_req = 1'b1; if_addr = 16'h0000;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0010;
    nd = 0; seq = '0;
    for (int k = 1; k <= 40 && nd < 4; k++) begin
      @(negedge clk);
      if (dm_done || if_done) begin
        seq[3 - nd] = dm_done;
        nd++;
      end
      @(posedge clk); #1;
    end
    check("t5_grant_count", nd, 4);
`ifdef MEM_ARB_FAIR_EN
    check("t5_grant_seq", seq, 4'b1010);
`else
    check("t5_grant_seq", seq, 4'b1111);
    check("t5_if_starved", if_stall, 1);
`endif
    if_req = 1'b0; dm_req = 1'b0;
    repeat (8) @(posedge clk);

    // LATENCY=1 instance: back-to-back loads every three cycles.
    #1 dm_req1 = 1'b1; dm_addr1 = 16'h0010;
    nd = 0; en_mask = '0; done_mask = '0; rdv = '0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1 if (nd == 2) dm_req1 = 1'b0;
      @(negedge clk);
      if (mem_en1) en_mask[k] = 1'b1;
      if (dm_done1) begin done_mask[k] = 1'b1; nd++; rdv = dm_rdata1; end
    end
    check("t6_en_cycles",   en_mask, 8'h12);
    check("t6_done_cycles", done_mask, 8'h24);
    check("t6_rdata",       rdv, 16'hBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_mem_arbiter
